data_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer in front of the shared `data_bus` memory block.
- Master 0 is the `zipocpu` load/store port. Master 1 is a secondary agent, such as the LED/memory-scan engine or a debug loader.
- Accepts request/ack transactions and serialises them onto the single bus port, holding address, control and write data stable for a fixed number of cycles.
- Returns captured read data and the bus exception flag to the winning master, using round-robin arbitration.

---
 rtl/data_bus_arbiter_if.sv | 26 ++
 rtl/data_bus_arbiter.sv | 103 ++++++++++
 tb/tb_data_bus_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// One master channel of the data bus arbiter.
// Request fields flow master->arbiter, grant/completion flow back.
interface data_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  rw;
    logic [1:0]            len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, rw, len, addr, wdata,
        input  gnt, ack, rdata, err
    );

    modport slave (
        input  req, rw, len, addr, wdata,
        output gnt, ack, rdata, err
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter serialising transactions
// onto the single data_bus port with a fixed access time.
module data_bus_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    data_bus_arbiter_if.slave     m0,
    data_bus_arbiter_if.slave     m1,
    output logic                  bus_rw,
    output logic [1:0]            bus_len,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_write,
    input  logic [DATA_WIDTH-1:0] bus_read,
    input  logic                  bus_exception
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       last;
    logic       win;
    logic       pick;
    logic       any_req;

    assign any_req = m0.req | m1.req;
    // On a tie the master that did not win last time goes first.
    assign pick    = (m0.req & m1.req) ? ~last : m1.req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;
            win       <= 1'b0;
            m0.gnt    <= 1'b0;
            m1.gnt    <= 1'b0;
            m0.ack    <= 1'b0;
            m1.ack    <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
            m0.err    <= 1'b0;
            m1.err    <= 1'b0;
            bus_rw    <= 1'b0;
            bus_len   <= 2'd0;
            bus_addr  <= '0;
            bus_write <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        win       <= pick;
                        last      <= pick;
                        m0.gnt    <= ~pick;
                        m1.gnt    <= pick;
                        bus_rw    <= pick ? m1.rw    : m0.rw;
                        bus_len   <= pick ? m1.len   : m0.len;
                        bus_addr  <= pick ? m1.addr  : m0.addr;
                        bus_write <= pick ? m1.wdata : m0.wdata;
                        cnt       <= WAIT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (win) begin
                            m1.rdata <= bus_read;
                            m1.err   <= bus_exception;
                            m1.ack   <= 1'b1;
                        end else begin
                            m0.rdata <= bus_read;
                            m0.err   <= bus_exception;
                            m0.ack   <= 1'b1;
                        end
                        m0.gnt    <= 1'b0;
                        m1.gnt    <= 1'b0;
                        bus_rw    <= 1'b0;
                        bus_len   <= 2'd0;
                        bus_addr  <= '0;
                        bus_write <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    m0.ack <= 1'b0;
                    m1.ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: one instance with
// single-cycle access, one with four-cycle access.
module tb_data_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          m;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_bus_arbiter_if #(AW, DW) a0 ();
    data_bus_arbiter_if #(AW, DW) a1 ();
    data_bus_arbiter_if #(AW, DW) b0 ();
    data_bus_arbiter_if #(AW, DW) b1 ();

    logic          bus_rw, bus_rw4;
    logic [1:0]    bus_len, bus_len4;
    logic [AW-1:0] bus_addr, bus_addr4;
    logic [DW-1:0] bus_write, bus_write4;
    logic [DW-1:0] bus_read, bus_read4;
    logic          bus_exc, bus_exc4;

    data_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .m0(a0), .m1(a1),
        .bus_rw(bus_rw), .bus_len(bus_len),
        .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_read(bus_read), .bus_exception(bus_exc)
    );

    data_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(4)
    ) dut4 (
        .clk(clk), .rst(rst), .m0(b0), .m1(b1),
        .bus_rw(bus_rw4), .bus_len(bus_len4),
        .bus_addr(bus_addr4), .bus_write(bus_write4),
        .bus_read(bus_read4), .bus_exception(bus_exc4)
    );

    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t q4[$];

    // Scoreboard for the single-cycle instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_assert++;
            if (a0.gnt && a1.gnt) begin
                n_fail++;
                $display("FAIL dual_gnt: both grants high at %0t", $time);
            end
            if (a0.ack || a1.ack) begin
                exp_t e;
                bit   m;
                n_assert++;
                m = a1.ack;
                if (a0.ack && a1.ack) begin
                    n_fail++;
                    $display("FAIL dual_ack: both acks high at %0t", $time);
                end else if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_ack: unexpected ack from m%0d", m);
                end else begin
                    e = q.pop_front();
                    if (m !== e.m
                        || (m ? a1.rdata : a0.rdata) !== e.rd
                        || (m ? a1.err : a0.err) !== e.er) begin
                        n_fail++;
                        $display("FAIL sb_ack: got m%0d rd=%h er=%b, need m%0d rd=%h er=%b",
                                 m, m ? a1.rdata : a0.rdata,
                                 m ? a1.err : a0.err, e.m, e.rd, e.er);
                    end
                end
            end
        end
    end

    // Scoreboard for the four-cycle instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_assert++;
            if (b0.gnt && b1.gnt) begin
                n_fail++;
                $display("FAIL dual_gnt4: both grants high at %0t", $time);
            end
            if (b0.ack || b1.ack) begin
                exp_t e;
                bit   m;
                n_assert++;
                m = b1.ack;
                if (b0.ack && b1.ack) begin
                    n_fail++;
                    $display("FAIL dual_ack4: both acks high at %0t", $time);
                end else if (q4.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_ack4: unexpected ack from m%0d", m);
                end else begin
                    e = q4.pop_front();
                    if (m !== e.m
                        || (m ? b1.rdata : b0.rdata) !== e.rd
                        || (m ? b1.err : b0.err) !== e.er) begin
                        n_fail++;
                        $display("FAIL sb_ack4: got m%0d rd=%h er=%b, need m%0d rd=%h er=%b",
                                 m, m ? b1.rdata : b0.rdata,
                                 m ? b1.err : b0.err, e.m, e.rd, e.er);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        a0.req = 0; a0.rw = 0; a0.len = 0; a0.addr = 0; a0.wdata = 0;
        a1.req = 0; a1.rw = 0; a1.len = 0; a1.addr = 0; a1.wdata = 0;
        b0.req = 0; b0.rw = 0; b0.len = 0; b0.addr = 0; b0.wdata = 0;
        b1.req = 0; b1.rw = 0; b1.len = 0; b1.addr = 0; b1.wdata = 0;
        bus_read = 0; bus_exc = 0; bus_read4 = 0; bus_exc4 = 0;
        #12;
        n_assert++;
        if ({a0.gnt, a1.gnt, a0.ack, a1.ack, a0.err, a1.err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b, need 000000",
                     {a0.gnt, a1.gnt, a0.ack, a1.ack, a0.err, a1.err});
        end
        n_assert++;
        if (a0.rdata !== 0 || a1.rdata !== 0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h, need 0", a0.rdata, a1.rdata);
        end
        n_assert++;
        if ({bus_rw, bus_len, bus_addr, bus_write} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got rw=%b len=%0d a=%h w=%h, need 0",
                     bus_rw, bus_len, bus_addr, bus_write);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        a0.rw = 0; a0.len = 0; a0.addr = 32'h100; a0.req = 1;
        bus_read = 32'h5A; bus_exc = 0;
        q.push_back('{1'b0, 32'h5A, 1'b0});
        @(negedge clk);
        n_assert++;
        if (a0.gnt !== 1 || bus_addr !== 32'h100 || bus_rw !== 0) begin
            n_fail++;
            $display("FAIL read_gnt: got gnt=%b addr=%h rw=%b, need 1 100 0",
                     a0.gnt, bus_addr, bus_rw);
        end
        @(negedge clk);
        n_assert++;
        if (a0.ack !== 1 || a0.gnt !== 0) begin
            n_fail++;
            $display("FAIL read_ack: got ack=%b gnt=%b, need 1 0", a0.ack, a0.gnt);
        end
        a0.req = 0;
        @(negedge clk);
        n_assert++;
        if (a0.ack !== 0 || bus_addr !== 0) begin
            n_fail++;
            $display("FAIL read_done: got ack=%b addr=%h, need 0 0", a0.ack, bus_addr);
        end
        n_assert++;
        if (a1.rdata !== 0 || a1.err !== 0 || a1.ack !== 0) begin
            n_fail++;
            $display("FAIL read_m1_hold: got rd=%h er=%b ack=%b, need 0 0 0",
                     a1.rdata, a1.err, a1.ack);
        end
    endtask

    task automatic test_tie_alternation();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0.rw = 0; a0.addr = 32'h10; a1.rw = 0; a1.addr = 32'h20;
        bus_exc = 0;
        for (int k = 0; k < 4; k++) q.push_back('{1'(k % 2), 32'h1000 + k, 1'b0});
        a0.req = 1; a1.req = 1;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = -1;
            for (int t = 0; t < 8 && w < 0; t++) begin
                @(negedge clk);
                if (a0.gnt) w = 0;
                else if (a1.gnt) w = 1;
            end
            n_assert++;
            if (w != k % 2) begin
                n_fail++;
                $display("FAIL tie_order[%0d]: granted %0d, need %0d", k, w, k % 2);
            end
            n_assert++;
            if (w >= 0 && bus_addr !== (w == 1 ? 32'h20 : 32'h10)) begin
                n_fail++;
                $display("FAIL tie_addr[%0d]: got %h", k, bus_addr);
            end
            bus_read = 32'h1000 + k;
            @(negedge clk);
            n_assert++;
            if ((w == 1 ? a1.ack : a0.ack) !== 1) begin
                n_fail++;
                $display("FAIL tie_ack[%0d]: got 0, need 1", k);
            end
            if (w == 1) a1.req = 0;
            else a0.req = 0;
            @(negedge clk);
            if (k < 3) begin
                if (w == 1) a1.req = 1;
                else a0.req = 1;
            end else begin
                a0.req = 0; a1.req = 0;
            end
        end
    endtask

    task automatic test_write_exception();
        @(negedge clk);
        a1.rw = 1; a1.len = 2'd2; a1.addr = 32'hFFFF_FFF0;
        a1.wdata = 32'h7F; a1.req = 1;
        bus_exc = 1; bus_read = 32'hDEAD_0001;
        q.push_back('{1'b1, 32'hDEAD_0001, 1'b1});
        @(negedge clk);
        n_assert++;
        if (a1.gnt !== 1 || bus_rw !== 1 || bus_write !== 32'h7F
            || bus_addr !== 32'hFFFF_FFF0 || bus_len !== 2'd2) begin
            n_fail++;
            $display("FAIL wr_bus: got g=%b rw=%b w=%h a=%h l=%0d, need 1 1 7f fffffff0 2",
                     a1.gnt, bus_rw, bus_write, bus_addr, bus_len);
        end
        @(negedge clk);
        n_assert++;
        if (a1.ack !== 1 || a1.err !== 1) begin
            n_fail++;
            $display("FAIL wr_err: got ack=%b err=%b, need 1 1", a1.ack, a1.err);
        end
        a1.req = 0; bus_exc = 0;
        @(negedge clk);
        a1.rw = 0; a1.addr = 32'h44; bus_read = 32'h33; a1.req = 1;
        q.push_back('{1'b1, 32'h33, 1'b0});
        @(negedge clk);
        @(negedge clk);
        n_assert++;
        if (a1.ack !== 1 || a1.err !== 0) begin
            n_fail++;
            $display("FAIL wr_clear: got ack=%b err=%b, need 1 0", a1.ack, a1.err);
        end
        a1.req = 0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        b0.rw = 0; b0.len = 2'd1; b0.addr = 32'h200; b0.req = 1;
        bus_read4 = 32'h40; bus_exc4 = 0;
        q4.push_back('{1'b0, 32'h43, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_assert++;
            if (b0.gnt !== 1 || b0.ack !== 0 || bus_addr4 !== 32'h200) begin
                n_fail++;
                $display("FAIL ws_hold[%0d]: got g=%b ack=%b a=%h, need 1 0 200",
                         i, b0.gnt, b0.ack, bus_addr4);
            end
            bus_read4 = 32'h40 + i;
            if (i == 0) b0.addr = 32'h999;
        end
        @(negedge clk);
        n_assert++;
        if (b0.ack !== 1 || b0.gnt !== 0) begin
            n_fail++;
            $display("FAIL ws_ack: got ack=%b gnt=%b, need 1 0", b0.ack, b0.gnt);
        end
        b0.req = 0;
        @(negedge clk);
        n_assert++;
        if (b0.ack !== 0) begin
            n_fail++;
            $display("FAIL ws_pulse: ack got %b, need 0", b0.ack);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a0.rw = 1; a0.addr = 32'h300; a0.wdata = 32'hAA; a0.req = 1;
        @(negedge clk);
        n_assert++;
        if (a0.gnt !== 1) begin
            n_fail++;
            $display("FAIL rm_gnt: got %b, need 1", a0.gnt);
        end
        #1 rst = 1'b1;
        #1;
        n_assert++;
        if ({a0.gnt, a0.ack, bus_rw} !== 3'b0 || bus_addr !== 0 || bus_write !== 0) begin
            n_fail++;
            $display("FAIL rm_abort: got g=%b ack=%b rw=%b a=%h w=%h, need 0",
                     a0.gnt, a0.ack, bus_rw, bus_addr, bus_write);
        end
        a0.req = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++;
            if (a0.ack !== 0 || a1.ack !== 0) begin
                n_fail++;
                $display("FAIL rm_noack[%0d]: got %b %b, need 0 0", i, a0.ack, a1.ack);
            end
        end
        a0.rw = 0; a0.addr = 32'h10; a1.rw = 0; a1.addr = 32'h20;
        bus_read = 32'h77; a0.req = 1; a1.req = 1;
        q.push_back('{1'b0, 32'h77, 1'b0});
        @(negedge clk);
        n_assert++;
        if (a0.gnt !== 1 || a1.gnt !== 0) begin
            n_fail++;
            $display("FAIL rm_tie: got g0=%b g1=%b, need 1 0", a0.gnt, a1.gnt);
        end
        a1.req = 0;
        @(negedge clk);
        a0.req = 0;
        @(negedge clk);
    endtask

    task automatic test_req_withdrawn();
        int acks;
        acks = 0;
        @(negedge clk);
        b1.rw = 0; b1.addr = 32'h500; b1.req = 1;
        bus_read4 = 32'h55;
        q4.push_back('{1'b1, 32'h55, 1'b0});
        @(negedge clk);
        n_assert++;
        if (b1.gnt !== 1) begin
            n_fail++;
            $display("FAIL wd_gnt: got %b, need 1", b1.gnt);
        end
        @(negedge clk);
        b1.req = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (b1.ack) acks++;
        end
        n_assert++;
        if (acks != 1 || b1.gnt !== 0) begin
            n_fail++;
            $display("FAIL wd_ack: got %0d acks gnt=%b, need 1 0", acks, b1.gnt);
        end
        b0.addr = 32'h600; b0.req = 1;
        q4.push_back('{1'b0, 32'h55, 1'b0});
        @(negedge clk);
        n_assert++;
        if (b0.gnt !== 1) begin
            n_fail++;
            $display("FAIL wd_idle: next grant got %b, need 1", b0.gnt);
        end
        b0.req = 0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_tie_alternation();
        test_write_exception();
        test_wait_states();
        test_reset_mid();
        test_req_withdrawn();
        n_assert++;
        if (q.size() != 0 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d pending, need 0", q.size(), q4.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
